multicycle_control: RTL and testbench

- Multi-cycle sequencing controller for the RV32I core.
- Replaces single-cycle combinational control. Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives the existing datapath strobes (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, AuipcLui, ALUop, PC select).
- Handshakes with the data memory (req/ack) and flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_control_pkg.sv | 46 ++++
 rtl/multicycle_control_classifier.sv | 37 +++
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
//   state_t       : controller FSM states
//   instr_class_t : instruction class produced by opcode_classifier
//   OP_*          : RV32I major opcodes supported by the controller
//   ALU_*         : alu_op encodings driven towards the ALU control
//   ASEL_*        : auipc_lui (ALU A-input mux) select encodings
package multicycle_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_IMM,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_LUI,
    CL_AUIPC,
    CL_ILLEGAL
  } instr_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] ASEL_PC   = 2'd0;
  localparam logic [1:0] ASEL_ZERO = 2'd1;
  localparam logic [1:0] ASEL_RS1  = 2'd2;

endpackage

// File: rtl/multicycle_control_classifier.sv
// opcode_classifier: combinational map from latched opcode/funct3 to an
// instruction class and a legal flag.
//   i_opcode [6:0] : latched instruction opcode
//   i_funct3 [2:0] : latched funct3 field
//   o_class        : instruction class (CL_ILLEGAL when not supported)
//   o_legal        : 1 when the instruction is supported
module opcode_classifier
  import multicycle_pkg::*;
(
  input  logic [6:0]   i_opcode,
  input  logic [2:0]   i_funct3,
  output instr_class_t o_class,
  output logic         o_legal
);

  always_comb begin
    o_class = CL_ILLEGAL;
    o_legal = 1'b0;
    case (i_opcode)
      OP_R:      begin o_class = CL_R;     o_legal = 1'b1; end
      OP_IMM:    begin o_class = CL_IMM;   o_legal = 1'b1; end
      OP_LOAD:   begin o_class = CL_LOAD;  o_legal = 1'b1; end
      OP_STORE:  begin o_class = CL_STORE; o_legal = 1'b1; end
      OP_LUI:    begin o_class = CL_LUI;   o_legal = 1'b1; end
      OP_AUIPC:  begin o_class = CL_AUIPC; o_legal = 1'b1; end
      OP_BRANCH: begin
        // Only BEQ/BNE: the datapath offers nothing but the Zero flag.
        if (i_funct3 == 3'b000 || i_funct3 == 3'b001) begin
          o_class = CL_BRANCH;
          o_legal = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencing controller for the RV32I core.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// drives the datapath strobes as Moore outputs of the state plus the
// latched opcode/funct3 (the branch decision also uses the ALU Zero flag).
// Ports:
//   clk, rst (async, active-high)
//   instr[31:0], zero, mem_ack                      : inputs
//   pc_write, pc_sel, ir_write, reg_write           : PC/IR/regfile strobes
//   mem_req, mem_read, mem_write, mem_to_reg        : data memory handshake
//   alu_src, auipc_lui[1:0], alu_op[1:0]            : ALU input/op selects
//   busy, error                                     : status
// Optional: define MULTICYCLE_CONTROL_PERF_EN to add cycle_count[31:0] and
// instret_count[31:0] performance counters.
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ack,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  auipc_lui,
  output logic [1:0]  alu_op,
  output logic        busy,
`ifdef MULTICYCLE_CONTROL_PERF_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count,
`endif
  output logic        error
);

  // Last MEM cycle allowed before timing out: the counter starts at 0 on
  // MEM entry, so MEM_TIMEOUT MEM cycles elapse before HALT.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t             r_state;
  logic [6:0]         r_opcode;
  logic [2:0]         r_funct3;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_error;
  instr_class_t       w_class;
  logic               w_legal;
  logic               w_take;
  logic               w_unused_instr;

  assign w_unused_instr = &{1'b0, instr[31:15], instr[11:7]};

  opcode_classifier u_classifier (
    .i_opcode (r_opcode),
    .i_funct3 (r_funct3),
    .o_class  (w_class),
    .o_legal  (w_legal)
  );

  // BEQ takes on zero, BNE (funct3[0]=1) on not-zero.
  assign w_take = zero ^ r_funct3[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_BOOT;
      r_opcode <= '0;
      r_funct3 <= '0;
      r_cnt    <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: r_state <= S_FETCH;
        S_FETCH: begin
          r_opcode <= instr[6:0];
          r_funct3 <= instr[14:12];
          r_state  <= S_DECODE;
        end
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXECUTE;
          end else begin
            r_state <= S_HALT;
            r_error <= 1'b1;
          end
        end
        S_EXECUTE: begin
          case (w_class)
            CL_LOAD, CL_STORE: begin
              r_state <= S_MEM;
              r_cnt   <= '0;
            end
            CL_BRANCH: r_state <= S_FETCH;
            default:   r_state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          // Ack is checked first so a same-cycle ack beats the timeout.
          if (mem_ack) begin
            r_state <= (w_class == CL_LOAD) ? S_WRITEBACK : S_FETCH;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_state <= S_HALT;
            r_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_BOOT;
      endcase
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    auipc_lui  = ASEL_PC;
    alu_op     = ALU_ADD;
    busy       = 1'b0;
    case (r_state)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: busy = 1'b1;
      S_EXECUTE: begin
        busy = 1'b1;
        case (w_class)
          CL_R: begin
            auipc_lui = ASEL_RS1;
            alu_op    = ALU_FUNCT;
          end
          CL_IMM: begin
            alu_src   = 1'b1;
            auipc_lui = ASEL_RS1;
            alu_op    = ALU_FUNCT;
          end
          CL_LOAD, CL_STORE: begin
            alu_src   = 1'b1;
            auipc_lui = ASEL_RS1;
          end
          CL_BRANCH: begin
            auipc_lui = ASEL_RS1;
            alu_op    = ALU_SUB;
            pc_write  = w_take;
            pc_sel    = w_take;
          end
          CL_LUI: begin
            alu_src   = 1'b1;
            auipc_lui = ASEL_ZERO;
          end
          CL_AUIPC: alu_src = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_read  = (w_class == CL_LOAD);
        mem_write = (w_class == CL_STORE);
      end
      S_WRITEBACK: begin
        busy       = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = (w_class == CL_LOAD);
      end
      default: ;
    endcase
  end

  assign error = r_error;

`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic r_dummy_unused;
  logic w_retire;

  // Transitions into FETCH from EXECUTE, MEM or WRITEBACK.
  assign w_retire = ((r_state == S_EXECUTE) && (w_class == CL_BRANCH)) ||
                    ((r_state == S_MEM) && mem_ack && (w_class == CL_STORE)) ||
                    (r_state == S_WRITEBACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (r_state != S_BOOT && r_state != S_HALT) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (w_retire) begin
        instret_count <= instret_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-cycle vector table
// followed by hand-written timeout, ack-race and performance sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        pc_write, pc_sel, ir_write, reg_write;
  logic        mem_req, mem_read, mem_write, mem_to_reg;
  logic        alu_src, busy, error;
  logic [1:0]  auipc_lui, alu_op;
`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] cycle_count, instret_count;
`endif

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .mem_ack    (mem_ack),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .mem_req    (mem_req),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .auipc_lui  (auipc_lui),
    .alu_op     (alu_op),
    .busy       (busy),
`ifdef MULTICYCLE_CONTROL_PERF_EN
    .cycle_count   (cycle_count),
    .instret_count (instret_count),
`endif
    .error      (error)
  );

  // {pc_write,pc_sel,ir_write,reg_write,mem_req,mem_read,mem_write,
  //  mem_to_reg,alu_src,auipc_lui[1:0],alu_op[1:0],busy,error}
  logic [14:0] w_out;
  assign w_out = {pc_write, pc_sel, ir_write, reg_write, mem_req, mem_read,
                  mem_write, mem_to_reg, alu_src, auipc_lui, alu_op, busy, error};

  localparam logic [14:0] O_BOOT   = 15'b0_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] O_FETCH  = 15'b1_0_1_0_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] O_DEC    = 15'b0_0_0_0_0_0_0_0_0_00_00_1_0;
  localparam logic [14:0] O_EX_R   = 15'b0_0_0_0_0_0_0_0_0_10_10_1_0;
  localparam logic [14:0] O_EX_I   = 15'b0_0_0_0_0_0_0_0_1_10_10_1_0;
  localparam logic [14:0] O_EX_LS  = 15'b0_0_0_0_0_0_0_0_1_10_00_1_0;
  localparam logic [14:0] O_EX_BT  = 15'b1_1_0_0_0_0_0_0_0_10_01_1_0;
  localparam logic [14:0] O_EX_BN  = 15'b0_0_0_0_0_0_0_0_0_10_01_1_0;
  localparam logic [14:0] O_EX_LUI = 15'b0_0_0_0_0_0_0_0_1_01_00_1_0;
  localparam logic [14:0] O_EX_AUI = 15'b0_0_0_0_0_0_0_0_1_00_00_1_0;
  localparam logic [14:0] O_MEM_LD = 15'b0_0_0_0_1_1_0_0_0_00_00_1_0;
  localparam logic [14:0] O_MEM_ST = 15'b0_0_0_0_1_0_1_0_0_00_00_1_0;
  localparam logic [14:0] O_WB_LD  = 15'b0_0_0_1_0_0_0_1_0_00_00_1_0;
  localparam logic [14:0] O_WB_ALU = 15'b0_0_0_1_0_0_0_0_0_00_00_1_0;
  localparam logic [14:0] O_HALT   = 15'b0_0_0_0_0_0_0_0_0_00_00_0_1;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW    = 32'h0000A183;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BNE   = 32'h00209463;
  localparam logic [31:0] I_BLT   = 32'h0020C463;
  localparam logic [31:0] I_ADDI  = 32'h00108093;
  localparam logic [31:0] I_LUI   = 32'h000010B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_ILL   = 32'h0000007F;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        ack;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic addv(input logic r, input logic [31:0] ins, input logic z,
                      input logic a, input logic [14:0] e, input string n);
    vec_t v;
    v.rst = r; v.instr = ins; v.zero = z; v.ack = a; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  // Drive inputs on the falling edge, sample 1 time unit later.
  task automatic step(input logic r, input logic [31:0] ins, input logic z,
                      input logic a);
    @(negedge clk);
    rst = r; instr = ins; zero = z; mem_ack = a;
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
  endtask

  initial begin
    int n_mem;
    // Reset, ADD
    addv(1, 0, 0, 0, O_BOOT,   "rst_boot");
    addv(0, 0, 0, 0, O_BOOT,   "boot_hold");
    addv(0, I_ADD, 0, 0, O_FETCH, "add_fetch");
    addv(0, 0, 0, 0, O_DEC,    "add_decode");
    addv(0, 0, 0, 0, O_EX_R,   "add_exec");
    addv(0, 0, 0, 0, O_WB_ALU, "add_wb");
    // LW, ack on 3rd MEM cycle
    addv(0, I_LW, 0, 0, O_FETCH, "lw_fetch");
    addv(0, 0, 0, 0, O_DEC,    "lw_decode");
    addv(0, 0, 0, 0, O_EX_LS,  "lw_exec");
    addv(0, 0, 0, 0, O_MEM_LD, "lw_mem1");
    addv(0, 0, 0, 0, O_MEM_LD, "lw_mem2");
    addv(0, 0, 0, 1, O_MEM_LD, "lw_mem3_ack");
    addv(0, 0, 0, 0, O_WB_LD,  "lw_wb");
    // BEQ taken / not taken, BNE not taken / taken
    addv(0, I_BEQ, 0, 0, O_FETCH, "beq1_fetch");
    addv(0, 0, 0, 0, O_DEC,    "beq1_decode");
    addv(0, 0, 1, 0, O_EX_BT,  "beq_z1_taken");
    addv(0, I_BEQ, 0, 0, O_FETCH, "beq2_fetch");
    addv(0, 0, 0, 0, O_DEC,    "beq2_decode");
    addv(0, 0, 0, 0, O_EX_BN,  "beq_z0_not");
    addv(0, I_BNE, 0, 0, O_FETCH, "bne1_fetch");
    addv(0, 0, 0, 0, O_DEC,    "bne1_decode");
    addv(0, 0, 1, 0, O_EX_BN,  "bne_z1_not");
    addv(0, I_BNE, 0, 0, O_FETCH, "bne2_fetch");
    addv(0, 0, 0, 0, O_DEC,    "bne2_decode");
    addv(0, 0, 0, 0, O_EX_BT,  "bne_z0_taken");
    // ADDI, LUI, AUIPC
    addv(0, I_ADDI, 0, 0, O_FETCH, "addi_fetch");
    addv(0, 0, 0, 0, O_DEC,    "addi_decode");
    addv(0, 0, 0, 0, O_EX_I,   "addi_exec");
    addv(0, 0, 0, 0, O_WB_ALU, "addi_wb");
    addv(0, I_LUI, 0, 0, O_FETCH, "lui_fetch");
    addv(0, 0, 0, 0, O_DEC,    "lui_decode");
    addv(0, 0, 0, 0, O_EX_LUI, "lui_exec");
    addv(0, 0, 0, 0, O_WB_ALU, "lui_wb");
    addv(0, I_AUIPC, 0, 0, O_FETCH, "auipc_fetch");
    addv(0, 0, 0, 0, O_DEC,    "auipc_decode");
    addv(0, 0, 0, 0, O_EX_AUI, "auipc_exec");
    addv(0, 0, 0, 0, O_WB_ALU, "auipc_wb");
    // SW with immediate ack, straight back to FETCH
    addv(0, I_SW, 0, 0, O_FETCH, "sw_fetch");
    addv(0, 0, 0, 0, O_DEC,    "sw_decode");
    addv(0, 0, 0, 0, O_EX_LS,  "sw_exec");
    addv(0, 0, 0, 1, O_MEM_ST, "sw_mem_ack");
    // Illegal opcode (stray ack outside MEM ignored), HALT sticky
    addv(0, I_ILL, 0, 1, O_FETCH, "ill_fetch");
    addv(0, 0, 0, 1, O_DEC,    "ill_decode");
    addv(0, 0, 0, 0, O_HALT,   "ill_halt");
    addv(0, I_ADD, 1, 1, O_HALT, "halt_absorb");
    addv(1, 0, 0, 0, O_BOOT,   "halt_rst");
    addv(0, 0, 0, 0, O_BOOT,   "boot2");
    // Reset during MEM of a LOAD
    addv(0, I_LW, 0, 0, O_FETCH, "lw2_fetch");
    addv(0, 0, 0, 0, O_DEC,    "lw2_decode");
    addv(0, 0, 0, 0, O_EX_LS,  "lw2_exec");
    addv(0, 0, 0, 0, O_MEM_LD, "lw2_mem");
    addv(1, 0, 0, 0, O_BOOT,   "mem_async_rst");
    addv(0, 0, 0, 0, O_BOOT,   "boot3");
    // Branch with unsupported funct3 is illegal
    addv(0, I_BLT, 0, 0, O_FETCH, "blt_fetch");
    addv(0, 0, 0, 0, O_DEC,    "blt_decode");
    addv(0, 0, 0, 0, O_HALT,   "blt_halt");

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].instr, tbl[i].zero, tbl[i].ack);
      chk(tbl[i].name, 32'(w_out), 32'(tbl[i].exp));
    end

    // STORE timeout: no ack, HALT after 16 MEM cycles
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, I_SW, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_mem = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0, 0);
      if (mem_req) n_mem++;
      else break;
    end
    chk("timeout_mem_cycles", 32'(n_mem), 32'd16);
    chk("timeout_error", 32'(error), 32'd1);
    chk("timeout_halt_out", 32'(w_out), 32'(O_HALT));
    for (int i = 0; i < 3; i++) begin
      step(0, I_ADD, 1, 1);
      chk("timeout_halt_hold", 32'(w_out), 32'(O_HALT));
    end

    // Ack on the very cycle the counter would time out: ack wins
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, I_SW, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_mem = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, 0, 0);
      if (mem_req) n_mem++;
    end
    step(0, 0, 0, 1);
    if (mem_req) n_mem++;
    chk("race_mem_cycles", 32'(n_mem), 32'd16);
    step(0, 0, 0, 0);
    chk("race_ack_wins", 32'(w_out), 32'(O_FETCH));

`ifdef MULTICYCLE_CONTROL_PERF_EN
    step(1, 0, 0, 0);
    chk("perf_rst_cycle", cycle_count, 32'd0);
    chk("perf_rst_instret", instret_count, 32'd0);
    step(0, 0, 0, 0);
    step(0, I_ADD, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, I_LW, 0, 0);  step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, I_BEQ, 0, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
    step(0, I_ADD, 0, 0);
    step(0, 0, 0, 0);
    chk("perf_cycle_count", cycle_count, 32'd13);
    chk("perf_instret", instret_count, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
